pim_dp_sequencer: RTL and testbench

Command-driven initiator for the two-register PIM DataPath. It accepts LOAD/EXEC commands over a valid/ready handshake and generates the datapath control sequence: reg_select, load_data and a single-cycle load_enable strobe for loads; opcode plus a settle wait for executes. It captures the datapath result and returns it over a valid/ready result channel. It sits between the memory-side command source and the DataPath instance.

---
 rtl/pim_dp_sequencer_pkg.sv | 18 +
 rtl/pim_dp_sequencer_if.sv | 19 +
 rtl/pim_dp_sequencer.sv | 109 ++++++++++
 tb/tb_pim_dp_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pim_dp_sequencer_pkg.sv
// pim_dp_sequencer_pkg: command encodings, opcode width and FSM states for the PIM datapath sequencer
package pim_dp_sequencer_pkg;
    localparam int OP_W = 2;
    typedef enum logic [1:0] {
        KIND_LOAD_A = 2'b00,
        KIND_LOAD_B = 2'b01,
        KIND_EXEC   = 2'b10,
        KIND_RSVD   = 2'b11
    } kind_t;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_SETUP,
        S_LD_STROBE,
        S_LD_HOLD,
        S_EX_SETTLE,
        S_RESP
    } state_t;
endpackage

// File: rtl/pim_dp_sequencer_if.sv
// pim_dp_sequencer_if: command and result valid/ready channels between command source and sequencer
interface pim_dp_sequencer_if #(parameter int DATA_W = 32);
    logic                                cmd_valid;
    logic                                cmd_ready;
    logic [1:0]                          cmd_kind;
    logic [DATA_W-1:0]                   cmd_data;
    logic [pim_dp_sequencer_pkg::OP_W-1:0] cmd_op;
    logic                                res_valid;
    logic                                res_ready;
    logic [DATA_W-1:0]                   res_data;
    modport master (
        output cmd_valid, cmd_kind, cmd_data, cmd_op, res_ready,
        input  cmd_ready, res_valid, res_data
    );
    modport slave (
        input  cmd_valid, cmd_kind, cmd_data, cmd_op, res_ready,
        output cmd_ready, res_valid, res_data
    );
endinterface

// File: rtl/pim_dp_sequencer.sv
// pim_dp_sequencer: turns LOAD/EXEC commands into two-register datapath control and returns EXEC results
module pim_dp_sequencer
    import pim_dp_sequencer_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    pim_dp_sequencer_if.slave bus,
    output logic              dp_reg_select,
    output logic [DATA_W-1:0] dp_load_data,
    output logic              dp_load_enable,
    output logic [OP_W-1:0]   dp_opcode,
    input  logic [DATA_W-1:0] dp_out,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              accept;
    kind_t             kind;

    assign kind           = kind_t'(bus.cmd_kind);
    assign bus.cmd_ready  = (state_q == S_IDLE) && !rst;
    assign accept         = bus.cmd_valid && bus.cmd_ready;
    assign bus.res_valid  = state_q == S_RESP;
    assign bus.res_data   = res_q;
    assign dp_reg_select  = sel_q;
    assign dp_load_data   = data_q;
    assign dp_load_enable = state_q == S_LD_STROBE;
    assign dp_opcode      = op_q;
    assign busy           = state_q != S_IDLE;
    assign op_count       = count_q;

    // State and datapath-facing registers; reset aborts any sequence in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            data_q  <= '0;
            res_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            res_q   <= res_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    // Next state: loads run setup/strobe/hold, execs settle then wait for the result handshake
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        res_d   = res_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (accept && (kind == KIND_LOAD_A || kind == KIND_LOAD_B)) begin
                    state_d = S_LD_SETUP;
                    sel_d   = bus.cmd_kind[0];
                    data_d  = bus.cmd_data;
                end else if (accept && kind == KIND_EXEC) begin
                    state_d = S_EX_SETTLE;
                    op_d    = bus.cmd_op;
                    cnt_d   = SW'(SETTLE_CYCLES - 1);
                end
            end
            S_LD_SETUP:  state_d = S_LD_STROBE;
            S_LD_STROBE: state_d = S_LD_HOLD;
            S_LD_HOLD: begin
                state_d = S_IDLE;
                count_d = count_q + CNT_W'(1);
            end
            S_EX_SETTLE: begin
                if (cnt_q == '0) begin
                    res_d   = dp_out;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - SW'(1);
                end
            end
            S_RESP: begin
                if (bus.res_ready) begin
                    state_d = S_IDLE;
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_pim_dp_sequencer.sv
// tb_pim_dp_sequencer: sequencer driving a behavioural two-register datapath, checked against a transaction-level model
module tb_pim_dp_sequencer;
    import pim_dp_sequencer_pkg::*;
    localparam int DW = 32;
    localparam int ST = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          dp_reg_select, dp_load_enable, busy;
    logic [DW-1:0] dp_load_data, dp_out;
    logic [1:0]    dp_opcode;
    logic [CW-1:0] op_count;
    logic          stub_en = 1'b0;
    logic [DW-1:0] stub_val = '0;
    logic [DW-1:0] a_q, b_q;
    int            strobes = 0;
    int            n_chk = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_a = '0;
    logic [DW-1:0] exp_b = '0;
    int            exp_cnt = 0;

    pim_dp_sequencer_if #(.DATA_W(DW)) bus ();

    pim_dp_sequencer #(.DATA_W(DW), .SETTLE_CYCLES(ST), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .dp_reg_select(dp_reg_select),
        .dp_load_data(dp_load_data),
        .dp_load_enable(dp_load_enable),
        .dp_opcode(dp_opcode),
        .dp_out(dp_out),
        .busy(busy),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        return op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? a & b : a ^ b;
    endfunction

    // Behavioural datapath: two registers loaded by the strobe, combinational result
    always @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (dp_load_enable) begin
            if (dp_reg_select) b_q <= dp_load_data;
            else a_q <= dp_load_data;
        end
    end

    // Strobe counter
    always @(posedge clk) if (dp_load_enable && !rst) strobes <= strobes + 1;

    assign dp_out = stub_en ? stub_val : alu(dp_opcode, a_q, b_q);

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [1:0] k, input logic [DW-1:0] d, input logic [1:0] op);
        for (int i = 0; i < 20 && !bus.cmd_ready; i++) @(negedge clk);
        n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL send_ready: cmd_ready=%b want 1", bus.cmd_ready); end
        bus.cmd_kind  = k;
        bus.cmd_data  = d;
        bus.cmd_op    = op;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input string name);
        for (int i = 0; i < 10 && !bus.res_valid; i++) @(negedge clk);
        n_chk++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL %s_timeout: res_valid=%b want 1", name, bus.res_valid); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_chk++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready_during: got %b want 0", bus.cmd_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", bus.cmd_ready); end
        n_chk++; if ({busy, bus.res_valid, dp_load_enable, dp_reg_select} !== 4'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {busy, bus.res_valid, dp_load_enable, dp_reg_select}); end
        send(KIND_EXEC, '0, 2'd1);
        n_chk++; if (busy !== 1'b1 || dp_opcode !== 2'd1) begin n_fail++; $display("FAIL rst_pre_settle: busy=%b op=%h want 1/1", busy, dp_opcode); end
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.cmd_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: ready=%b busy=%b want 0/0", bus.cmd_ready, busy); end
        @(negedge clk);
        rst = 1'b0;
        exp_a = '0; exp_b = '0; exp_cnt = 0;
        @(negedge clk);
        n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready_after: got %b want 1", bus.cmd_ready); end
        n_chk++; if (dp_opcode !== 2'd0 || dp_load_data !== '0 || bus.res_data !== '0 || op_count !== '0) begin n_fail++; $display("FAIL rst_mid_values: op=%h ld=%h res=%h cnt=%0d want all 0", dp_opcode, dp_load_data, bus.res_data, op_count); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_result: res_valid=%b want 0", bus.res_valid); end
        end
    endtask

    task automatic test_load();
        int s0 = strobes;
        send(KIND_LOAD_A, 32'h44332211, 2'd0);
        n_chk++; if ({dp_reg_select, dp_load_enable} !== 2'b00 || dp_load_data !== 32'h44332211) begin n_fail++; $display("FAIL ld_setup: sel=%b en=%b data=%h want 0/0/44332211", dp_reg_select, dp_load_enable, dp_load_data); end
        @(negedge clk);
        n_chk++; if (dp_load_enable !== 1'b1 || dp_load_data !== 32'h44332211) begin n_fail++; $display("FAIL ld_strobe: en=%b data=%h want 1/44332211", dp_load_enable, dp_load_data); end
        @(negedge clk);
        n_chk++; if (dp_load_enable !== 1'b0 || dp_reg_select !== 1'b0 || dp_load_data !== 32'h44332211 || bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ld_hold: en=%b sel=%b data=%h ready=%b want 0/0/44332211/0", dp_load_enable, dp_reg_select, dp_load_data, bus.cmd_ready); end
        @(negedge clk);
        exp_a = 32'h44332211; exp_cnt++;
        n_chk++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ld_ready_4: got %b want 1", bus.cmd_ready); end
        n_chk++; if (op_count !== CW'(exp_cnt)) begin n_fail++; $display("FAIL ld_count: got %0d want %0d", op_count, CW'(exp_cnt)); end
        n_chk++; if (strobes - s0 != 1 || a_q !== exp_a) begin n_fail++; $display("FAIL ld_one_strobe: strobes=%0d a=%h want 1/%h", strobes - s0, a_q, exp_a); end
    endtask

    task automatic test_exec();
        send(KIND_LOAD_B, 32'h11223344, 2'd0);
        cycles(3);
        exp_b = 32'h11223344; exp_cnt++;
        n_chk++; if (b_q !== exp_b) begin n_fail++; $display("FAIL ldb_reg: got %h want %h", b_q, exp_b); end
        stub_en = 1'b1; stub_val = 32'h55665566; bus.res_ready = 1'b0;
        send(KIND_EXEC, '0, 2'd1);
        for (int i = 0; i < ST; i++) begin
            n_chk++; if (dp_opcode !== 2'd1 || bus.res_valid !== 1'b0 || dp_load_enable !== 1'b0) begin n_fail++; $display("FAIL ex_settle%0d: op=%h rv=%b en=%b want 1/0/0", i, dp_opcode, bus.res_valid, dp_load_enable); end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h55665566) begin n_fail++; $display("FAIL ex_hold%0d: rv=%b data=%h want 1/55665566", i, bus.res_valid, bus.res_data); end
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0; stub_en = 1'b0; exp_cnt++;
        n_chk++; if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || dp_opcode !== 2'd1) begin n_fail++; $display("FAIL ex_done: rv=%b ready=%b op=%h want 0/1/1", bus.res_valid, bus.cmd_ready, dp_opcode); end
        n_chk++; if (op_count !== CW'(exp_cnt)) begin n_fail++; $display("FAIL ex_count: got %0d want %0d", op_count, CW'(exp_cnt)); end
    endtask

    task automatic test_back_to_back();
        bus.res_ready = 1'b0;
        bus.cmd_kind = KIND_EXEC; bus.cmd_op = 2'd2; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_op = 2'd3;
        wait_res("b2b_first");
        n_chk++; if (bus.res_data !== alu(2'd2, exp_a, exp_b)) begin n_fail++; $display("FAIL b2b_first_data: got %h want %h", bus.res_data, alu(2'd2, exp_a, exp_b)); end
        cycles(2);
        n_chk++; if (bus.cmd_ready !== 1'b0 || dp_opcode !== 2'd2) begin n_fail++; $display("FAIL b2b_blocked: ready=%b op=%h want 0/2", bus.cmd_ready, dp_opcode); end
        bus.res_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || dp_opcode !== 2'd2) begin n_fail++; $display("FAIL b2b_between: rv=%b ready=%b op=%h want 0/1/2", bus.res_valid, bus.cmd_ready, dp_opcode); end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n_chk++; if (dp_opcode !== 2'd3) begin n_fail++; $display("FAIL b2b_second_op: got %h want 3", dp_opcode); end
        wait_res("b2b_second");
        n_chk++; if (bus.res_data !== alu(2'd3, exp_a, exp_b)) begin n_fail++; $display("FAIL b2b_second_data: got %h want %h", bus.res_data, alu(2'd3, exp_a, exp_b)); end
        @(negedge clk);
        bus.res_ready = 1'b0; exp_cnt += 2;
        n_chk++; if (bus.res_valid !== 1'b0 || op_count !== CW'(exp_cnt) || dp_opcode !== 2'd3) begin n_fail++; $display("FAIL b2b_end: rv=%b cnt=%0d op=%h want 0/%0d/3", bus.res_valid, op_count, CW'(exp_cnt), dp_opcode); end
    endtask

    task automatic test_reserved();
        logic [DW-1:0] d0 = dp_load_data;
        logic          s0 = dp_reg_select;
        logic [1:0]    o0 = dp_opcode;
        int            k0 = strobes;
        send(KIND_RSVD, $urandom, 2'($urandom_range(0, 3)));
        n_chk++; if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rsvd_ready: ready=%b busy=%b want 1/0", bus.cmd_ready, busy); end
        n_chk++; if (dp_load_data !== d0 || dp_reg_select !== s0 || dp_opcode !== o0 || op_count !== CW'(exp_cnt)) begin n_fail++; $display("FAIL rsvd_unchanged: data=%h sel=%b op=%h cnt=%0d want %h/%b/%h/%0d", dp_load_data, dp_reg_select, dp_opcode, op_count, d0, s0, o0, CW'(exp_cnt)); end
        cycles(3);
        n_chk++; if (strobes != k0 || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rsvd_quiet: strobes=%0d rv=%b want %0d/0", strobes, bus.res_valid, k0); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [1:0]    k = 2'($urandom_range(0, 3));
            logic [DW-1:0] d = $urandom;
            logic [1:0]    op = 2'($urandom_range(0, 3));
            int            k0 = strobes;
            send(k, d, op);
            if (k == KIND_EXEC) begin
                wait_res("rnd_exec");
                n_chk++; if (bus.res_data !== alu(op, exp_a, exp_b)) begin n_fail++; $display("FAIL rnd_exec_data: op=%0d got %h want %h", op, bus.res_data, alu(op, exp_a, exp_b)); end
                cycles($urandom_range(0, 3));
                bus.res_ready = 1'b1;
                @(negedge clk);
                bus.res_ready = 1'b0;
                exp_cnt++;
            end else if (k != KIND_RSVD) begin
                cycles(3);
                if (k[0]) exp_b = d; else exp_a = d;
                exp_cnt++;
                n_chk++; if (strobes - k0 != 1 || a_q !== exp_a || b_q !== exp_b) begin n_fail++; $display("FAIL rnd_load: strobes=%0d a=%h b=%h want 1/%h/%h", strobes - k0, a_q, b_q, exp_a, exp_b); end
            end
            n_chk++; if (op_count !== CW'(exp_cnt) || bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_count: cnt=%0d rv=%b want %0d/0", op_count, bus.res_valid, CW'(exp_cnt)); end
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        exp_a = '0; exp_b = '0; exp_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            send(2'($urandom_range(0, 1)), $urandom, 2'd0);
            cycles(3);
            n_chk++; if (op_count !== CW'((i + 1) % 4)) begin n_fail++; $display("FAIL wrap_count%0d: got %0d want %0d", i, op_count, (i + 1) % 4); end
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_kind  = '0;
        bus.cmd_data  = '0;
        bus.cmd_op    = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_load();
        test_exec();
        test_back_to_back();
        test_reserved();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
